// File: rtl/collision_pkg.sv
// collision_pkg: shared types and helpers for the collision engine.
//   state_e     - scan controller states
//   pos_t       - {x, y} coordinate pair, built by make_pos()
//   lowest_set  - priority encoder used for first_hit_idx
package collision_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

    localparam int unsigned DefSpriteSize = 16;
    localparam int unsigned DefTileShift  = 5;

    // Widest coordinate / slot count the helpers below can carry.
    localparam int unsigned PosMaxW    = 16;
    localparam int unsigned MaxEnemies = 32;

    typedef struct packed {
        logic [PosMaxW-1:0] x;
        logic [PosMaxW-1:0] y;
    } pos_t;

    // Callers zero-extend COORD_W-wide coordinates into the PosMaxW fields.
    function automatic pos_t make_pos(input logic [PosMaxW-1:0] x,
                                      input logic [PosMaxW-1:0] y);
        pos_t p;
        p.x = x;
        p.y = y;
        return p;
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic int unsigned lowest_set(input logic [MaxEnemies-1:0] mask);
        int unsigned idx;
        idx = 0;
        for (int i = MaxEnemies - 1; i >= 0; i--) begin
            if (mask[i]) idx = unsigned'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_overlap.sv
// axis_overlap: single-axis sprite overlap test (purely combinational).
//   p_i  - player coordinate
//   e_i  - enemy coordinate
//   ov_o - 1 when the two coordinates lie within SPRITE_SIZE of each other,
//          touching edges included
module axis_overlap #(
    parameter int unsigned COORD_W     = 10,
    parameter int unsigned SPRITE_SIZE = 16
) (
    input  logic [COORD_W-1:0] p_i,
    input  logic [COORD_W-1:0] e_i,
    output logic               ov_o
);

    // One extra bit so coordinate + reach never wraps.
    logic [COORD_W:0] p_ext, e_ext, p_reach, e_reach;

    always_comb begin
        p_ext   = {1'b0, p_i};
        e_ext   = {1'b0, e_i};
        p_reach = p_ext + (COORD_W + 1)'(SPRITE_SIZE);
        e_reach = e_ext + (COORD_W + 1)'(SPRITE_SIZE);
        ov_o    = ((e_ext >= p_ext) && (e_ext <= p_reach)) ||
                  ((p_ext >= e_ext) && (p_ext <= e_reach));
    end

endmodule

// File: rtl/collision_engine.sv
// collision_engine: per-frame player/enemy collision scan, one slot per clock.
//   clk, rst            - clock, asynchronous active-high reset
//   start               - begin a scan (accepted only when idle)
//   player_pos          - {x, y} of the player
//   enemy_pos           - NUM_ENEMIES packed {x, y} slots, slot 0 in the LSBs
//   enemy_active        - per-slot enable
//   busy / done         - scan in progress / one-cycle result-update pulse
//   hit, hit_mask       - overlap results of the last completed scan
//   first_hit_idx       - lowest set bit of hit_mask (0 if none)
//   damage              - rate-limited pulse, concurrent with done
//   pblockposx/y        - tile coordinates of the snapshotted player
module collision_engine
    import collision_pkg::*;
#(
    parameter  int unsigned NUM_ENEMIES    = 4,
    parameter  int unsigned COORD_W        = 10,
    parameter  int unsigned SPRITE_SIZE    = DefSpriteSize,
    parameter  int unsigned TILE_SHIFT     = DefTileShift,
    parameter  int unsigned COOLDOWN_SCANS = 3,
    localparam int unsigned IdxW  = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1,
    localparam int unsigned TileW = COORD_W - TILE_SHIFT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [2*COORD_W-1:0]           player_pos,
    input  logic [NUM_ENEMIES*2*COORD_W-1:0] enemy_pos,
    input  logic [NUM_ENEMIES-1:0]         enemy_active,
    output logic                           busy,
    output logic                           done,
    output logic                           hit,
    output logic [NUM_ENEMIES-1:0]         hit_mask,
    output logic [IdxW-1:0]                first_hit_idx,
    output logic                           damage,
    output logic [TileW-1:0]               pblockposx,
    output logic [TileW-1:0]               pblockposy
);

    localparam int unsigned CoolW =
        (COOLDOWN_SCANS > 0) ? $clog2(COOLDOWN_SCANS + 1) : 1;

    if (COORD_W > PosMaxW) begin : g_coord_chk
        $error("COORD_W exceeds collision_pkg::PosMaxW");
    end
    if (NUM_ENEMIES > MaxEnemies) begin : g_enemy_chk
        $error("NUM_ENEMIES exceeds collision_pkg::MaxEnemies");
    end

    state_e                   state_q, state_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [CoolW-1:0]         cool_q, cool_d;
    logic [COORD_W-1:0]       px_q, px_d, py_q, py_d;
    logic [COORD_W-1:0]       ex_q [NUM_ENEMIES];
    logic [COORD_W-1:0]       ex_d [NUM_ENEMIES];
    logic [COORD_W-1:0]       ey_q [NUM_ENEMIES];
    logic [COORD_W-1:0]       ey_d [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0]   act_q, act_d;
    logic [NUM_ENEMIES-1:0]   work_q, work_d;
    logic [NUM_ENEMIES-1:0]   hit_mask_q, hit_mask_d;
    logic                     damage_q, damage_d;

    pos_t plr, enm;
    logic ov_x, ov_y;

    assign plr = make_pos(PosMaxW'(px_q), PosMaxW'(py_q));
    assign enm = make_pos(PosMaxW'(ex_q[idx_q]), PosMaxW'(ey_q[idx_q]));

    // Zero-extended inputs compare identically to COORD_W-wide ones.
    axis_overlap #(
        .COORD_W     (PosMaxW),
        .SPRITE_SIZE (SPRITE_SIZE)
    ) u_ov_x (
        .p_i  (plr.x),
        .e_i  (enm.x),
        .ov_o (ov_x)
    );

    axis_overlap #(
        .COORD_W     (PosMaxW),
        .SPRITE_SIZE (SPRITE_SIZE)
    ) u_ov_y (
        .p_i  (plr.y),
        .e_i  (enm.y),
        .ov_o (ov_y)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cool_d     = cool_q;
        px_d       = px_q;
        py_d       = py_q;
        ex_d       = ex_q;
        ey_d       = ey_q;
        act_d      = act_q;
        work_d     = work_q;
        hit_mask_d = hit_mask_q;
        damage_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    px_d  = player_pos[2*COORD_W-1:COORD_W];
                    py_d  = player_pos[COORD_W-1:0];
                    for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
                        ex_d[i] = enemy_pos[(2*i+1)*COORD_W +: COORD_W];
                        ey_d[i] = enemy_pos[2*i*COORD_W +: COORD_W];
                    end
                    act_d   = enemy_active;
                    work_d  = '0;
                    idx_d   = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                work_d[idx_q] = act_q[idx_q] & ov_x & ov_y;
                idx_d         = idx_q + IdxW'(1);
                if (idx_q == IdxW'(NUM_ENEMIES - 1)) begin
                    // Results and damage land on the edge entering StDone.
                    idx_d      = '0;
                    state_d    = StDone;
                    hit_mask_d = work_d;
                    if ((|work_d) && (cool_q == '0)) begin
                        damage_d = 1'b1;
                        cool_d   = CoolW'(COOLDOWN_SCANS);
                    end else if (cool_q != '0) begin
                        cool_d = cool_q - CoolW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cool_q     <= '0;
            px_q       <= '0;
            py_q       <= '0;
            for (int i = 0; i < int'(NUM_ENEMIES); i++) begin
                ex_q[i] <= '0;
                ey_q[i] <= '0;
            end
            act_q      <= '0;
            work_q     <= '0;
            hit_mask_q <= '0;
            damage_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cool_q     <= cool_d;
            px_q       <= px_d;
            py_q       <= py_d;
            ex_q       <= ex_d;
            ey_q       <= ey_d;
            act_q      <= act_d;
            work_q     <= work_d;
            hit_mask_q <= hit_mask_d;
            damage_q   <= damage_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign damage        = damage_q;
    assign hit_mask      = hit_mask_q;
    assign hit           = |hit_mask_q;
    assign first_hit_idx = IdxW'(lowest_set(MaxEnemies'(hit_mask_q)));
    assign pblockposx    = px_q[COORD_W-1:TILE_SHIFT];
    assign pblockposy    = py_q[COORD_W-1:TILE_SHIFT];

endmodule
